// File: rtl/gysc_fifo_ctrl.sv
// Decimating XYZ history FIFO controller: packs frames into a single-port SRAM and serves host pops.
// Optional watermark interrupt is built when GYSC_FIFO_WMARK_EN is defined.
module gysc_fifo_ctrl #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_en,
    input  logic          overwrite,
    input  logic [3:0]    odr_div,
    input  logic          flush,
    input  logic          sample_valid,
    input  logic [31:0]   x_data,
    input  logic [31:0]   y_data,
    input  logic [31:0]   z_data,
    input  logic          pop_req,
    output logic [31:0]   pop_x,
    output logic [31:0]   pop_y,
    output logic [31:0]   pop_z,
    output logic          pop_done,
    output logic          pop_empty,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          ovf_clr,
    input  logic [AW:0]   wmark,
    output logic          wmark_irq,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW+1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [2:0]    dbg_state
);

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR0, ST_WR1, ST_WR2, ST_RD0, ST_RD1, ST_RD2, ST_RD3
    } state_e;

    state_e        state_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic [3:0]    dec_cnt_q, dec_cnt_d;
    logic          cap_fire;
    logic          wr_pending_q, rd_pending_q, empty_pop_q, ovw_q, overflow_q;
    logic [31:0]   stg_x_q, stg_y_q, stg_z_q;
    logic          mem_en_q, mem_we_q;
    logic [AW+1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   pop_x_q, pop_y_q, pop_z_q;
    logic          pop_done_q, pop_empty_q;
    logic          full_w;

    assign full_w = (level_q == DEPTH);

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        cap_fire  = 1'b0;
        if (!fifo_en) begin
            dec_cnt_d = '0;
        end else if (sample_valid) begin
            if (dec_cnt_q >= odr_div) begin
                cap_fire  = 1'b1;
                dec_cnt_d = '0;
            end else begin
                dec_cnt_d = dec_cnt_q + 4'd1;
            end
        end
    end

    // pop_req is a one-cycle request accepted only while no pop is pending; every accepted
    // request is answered by exactly one pop_done pulse unless flush aborts it first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dec_cnt_q    <= '0;
            wr_pending_q <= 1'b0;
            rd_pending_q <= 1'b0;
            empty_pop_q  <= 1'b0;
            ovw_q        <= 1'b0;
            overflow_q   <= 1'b0;
            stg_x_q      <= '0;
            stg_y_q      <= '0;
            stg_z_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            pop_x_q      <= QNAN;
            pop_y_q      <= QNAN;
            pop_z_q      <= QNAN;
            pop_done_q   <= 1'b0;
            pop_empty_q  <= 1'b0;
        end else if (flush) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dec_cnt_q    <= '0;
            wr_pending_q <= 1'b0;
            rd_pending_q <= 1'b0;
            empty_pop_q  <= 1'b0;
            ovw_q        <= 1'b0;
            overflow_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            pop_done_q   <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            pop_done_q <= 1'b0;
            dec_cnt_q  <= dec_cnt_d;
            if (ovf_clr)
                overflow_q <= 1'b0;
            if (pop_req && !rd_pending_q)
                rd_pending_q <= 1'b1;
            if (cap_fire) begin
                if (wr_pending_q) begin
                    overflow_q <= 1'b1;
                end else begin
                    stg_x_q      <= x_data;
                    stg_y_q      <= y_data;
                    stg_z_q      <= z_data;
                    wr_pending_q <= 1'b1;
                end
            end
            // Empty pops answer one cycle after the IDLE decision without touching the SRAM.
            if (empty_pop_q) begin
                empty_pop_q  <= 1'b0;
                rd_pending_q <= 1'b0;
                pop_x_q      <= QNAN;
                pop_y_q      <= QNAN;
                pop_z_q      <= QNAN;
                pop_done_q   <= 1'b1;
                pop_empty_q  <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (wr_pending_q) begin
                        if (full_w)
                            overflow_q <= 1'b1;
                        if (full_w && !overwrite) begin
                            wr_pending_q <= 1'b0;
                        end else begin
                            if (full_w)
                                rd_ptr_q <= rd_ptr_q + 1'b1;
                            ovw_q       <= full_w;
                            state_q     <= ST_WR0;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {wr_ptr_q, 2'd0};
                            mem_wdata_q <= stg_x_q;
                        end
                    end else if (rd_pending_q && !empty_pop_q) begin
                        if (level_q == '0) begin
                            empty_pop_q <= 1'b1;
                        end else begin
                            state_q    <= ST_RD0;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= {rd_ptr_q, 2'd0};
                        end
                    end
                end
                ST_WR0: begin
                    state_q     <= ST_WR1;
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= {wr_ptr_q, 2'd1};
                    mem_wdata_q <= stg_y_q;
                end
                ST_WR1: begin
                    state_q     <= ST_WR2;
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= {wr_ptr_q, 2'd2};
                    mem_wdata_q <= stg_z_q;
                end
                ST_WR2: begin
                    wr_ptr_q     <= wr_ptr_q + 1'b1;
                    wr_pending_q <= 1'b0;
                    if (!ovw_q)
                        level_q <= level_q + 1'b1;
                    // A waiting pop starts straight away; the FIFO cannot be empty after a write.
                    if (rd_pending_q) begin
                        state_q    <= ST_RD0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {rd_ptr_q, 2'd0};
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD0: begin
                    state_q    <= ST_RD1;
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= {rd_ptr_q, 2'd1};
                end
                ST_RD1: begin
                    state_q    <= ST_RD2;
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= {rd_ptr_q, 2'd2};
                    pop_x_q    <= mem_rdata;
                end
                ST_RD2: begin
                    state_q <= ST_RD3;
                    pop_y_q <= mem_rdata;
                end
                ST_RD3: begin
                    state_q      <= ST_IDLE;
                    pop_z_q      <= mem_rdata;
                    rd_ptr_q     <= rd_ptr_q + 1'b1;
                    level_q      <= level_q - 1'b1;
                    rd_pending_q <= 1'b0;
                    pop_done_q   <= 1'b1;
                    pop_empty_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef GYSC_FIFO_WMARK_EN
    logic wmark_irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wmark_irq_q <= 1'b0;
        else
            wmark_irq_q <= (wmark != '0) && (level_q >= wmark);
    end

    assign wmark_irq = wmark_irq_q;
`else
    logic unused_wmark;
    assign unused_wmark = ^wmark;
    assign wmark_irq    = 1'b0;
`endif

    assign pop_x     = pop_x_q;
    assign pop_y     = pop_y_q;
    assign pop_z     = pop_z_q;
    assign pop_done  = pop_done_q;
    assign pop_empty = pop_empty_q;
    assign level     = level_q;
    assign full      = full_w;
    assign empty     = (level_q == '0);
    assign overflow  = overflow_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gysc_fifo_ctrl.sv
// Bench for gysc_fifo_ctrl: random frames checked against a frame-queue model of the FIFO.
// Define GYSC_FIFO_WMARK_EN for both files to exercise the watermark flag.
module tb_gysc_fifo_ctrl;

    localparam int          AW    = 2;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_en, overwrite, flush, sample_valid, pop_req, ovf_clr;
    logic [3:0]    odr_div;
    logic [31:0]   x_data, y_data, z_data;
    logic [31:0]   pop_x, pop_y, pop_z;
    logic          pop_done, pop_empty, full, empty, overflow, wmark_irq;
    logic [AW:0]   level, wmark;
    logic          mem_en, mem_we;
    logic [AW+1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [2:0]    dbg_state;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [95:0]   exp_q[$];
    int            since = 0;
    logic          ovf_m = 1'b0;
    int            en_cnt = 0;
    logic [AW+1:0] wr_addr_q[$];
    logic [31:0]   sram [0:(4*DEPTH)-1];

    gysc_fifo_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_en(fifo_en), .overwrite(overwrite),
        .odr_div(odr_div), .flush(flush), .sample_valid(sample_valid),
        .x_data(x_data), .y_data(y_data), .z_data(z_data), .pop_req(pop_req),
        .pop_x(pop_x), .pop_y(pop_y), .pop_z(pop_z), .pop_done(pop_done),
        .pop_empty(pop_empty), .level(level), .full(full), .empty(empty),
        .overflow(overflow), .ovf_clr(ovf_clr), .wmark(wmark), .wmark_irq(wmark_irq),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // clock and SRAM model
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4*DEPTH; i++) sram[i] = '0;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt++;
            if (mem_we) begin
                sram[mem_addr] <= mem_wdata;
                wr_addr_q.push_back(mem_addr);
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // scoreboard
    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string where);
        logic exp_wm;
`ifdef GYSC_FIFO_WMARK_EN
        exp_wm = (wmark != 0) && (exp_q.size() >= int'(wmark));
`else
        exp_wm = 1'b0;
`endif
        chk({where, ":level"},    96'(level),     96'(exp_q.size()));
        chk({where, ":full"},     96'(full),      96'(exp_q.size() == DEPTH));
        chk({where, ":empty"},    96'(empty),     96'(exp_q.size() == 0));
        chk({where, ":overflow"}, 96'(overflow),  96'(ovf_m));
        chk({where, ":wmark"},    96'(wmark_irq), 96'(exp_wm));
    endtask

    function automatic bit dec_model();
        if (!fifo_en) begin
            since = 0;
            return 1'b0;
        end
        since++;
        if (since > int'(odr_div)) begin
            since = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_capture(input logic [95:0] f);
        if (exp_q.size() == DEPTH) begin
            ovf_m = 1'b1;
            if (overwrite) begin
                void'(exp_q.pop_front());
                exp_q.push_back(f);
            end
        end else begin
            exp_q.push_back(f);
        end
    endfunction

    // driver tasks
    task automatic send_sample();
        logic [31:0] xv, yv, zv;
        xv = $urandom; yv = $urandom; zv = $urandom;
        @(negedge clk);
        x_data = xv; y_data = yv; z_data = zv; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (dec_model()) model_capture({xv, yv, zv});
        repeat (6) @(negedge clk);
    endtask

    task automatic do_pop(input string tag, input bit with_sample);
        logic [95:0] f, expf;
        logic        exp_empty;
        int          exp_lat, lat;
        bit          seen;
        f = {$urandom, $urandom, $urandom};
        if (with_sample && dec_model()) model_capture(f);
        exp_lat = with_sample ? 8 : ((exp_q.size() == 0) ? 2 : 5);
        if (exp_q.size() == 0) begin
            expf = {QNAN, QNAN, QNAN};
            exp_empty = 1'b1;
        end else begin
            expf = exp_q.pop_front();
            exp_empty = 1'b0;
        end
        @(negedge clk);
        pop_req = 1'b1;
        if (with_sample) begin
            x_data = f[95:64]; y_data = f[63:32]; z_data = f[31:0]; sample_valid = 1'b1;
        end
        @(negedge clk);
        pop_req = 1'b0; sample_valid = 1'b0;
        lat = 0; seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (pop_done) begin
                seen = 1'b1;
                lat = c;
            end
        end
        chk({tag, ":done_seen"}, 96'(seen), 96'(1));
        chk({tag, ":latency"},   96'(lat),  96'(exp_lat));
        chk({tag, ":data"},      {pop_x, pop_y, pop_z}, expf);
        chk({tag, ":pop_empty"}, 96'(pop_empty), 96'(exp_empty));
        @(negedge clk);
        chk({tag, ":done_pulse"}, 96'(pop_done), 96'(0));
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        exp_q.delete(); ovf_m = 1'b0; since = 0;
        @(negedge clk);
    endtask

    task automatic do_ovf_clr();
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        ovf_m = 1'b0;
    endtask

    initial begin
        int en0, aborted;
        fifo_en = 1'b0; overwrite = 1'b0; odr_div = 4'd0; flush = 1'b0;
        sample_valid = 1'b0; pop_req = 1'b0; ovf_clr = 1'b0; wmark = '0;
        x_data = '0; y_data = '0; z_data = '0;

        repeat (3) @(negedge clk);
        chk("rst:pop_data", {pop_x, pop_y, pop_z}, {QNAN, QNAN, QNAN});
        chk("rst:pop_flags", 96'({pop_done, pop_empty}), 96'(0));
        chk("rst:mem", 96'({mem_en, mem_we, mem_addr, mem_wdata}), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk_status("rst");

        // pop on an empty FIFO never touches the SRAM
        en0 = en_cnt;
        do_pop("empty_pop", 1'b0);
        chk("empty_pop:mem_en", 96'(en_cnt - en0), 96'(0));
        chk_status("empty_pop");

        // decimation by 3: samples 3, 6, 9 are kept
        do_flush();
        wr_addr_q.delete();
        fifo_en = 1'b1; odr_div = 4'd2;
        for (int i = 0; i < 9; i++) send_sample();
        chk("dec:level3", 96'(level), 96'(3));
        chk_status("dec");
        chk("dec:n_writes", 96'(wr_addr_q.size()), 96'(9));
        for (int i = 0; i < 9 && i < wr_addr_q.size(); i++)
            chk("dec:addr", 96'(wr_addr_q[i]), 96'(((i / 3) << 2) | (i % 3)));
        repeat (3) do_pop("dec_pop", 1'b0);
        chk_status("dec_drain");

        // full, drop newest
        do_flush();
        odr_div = 4'd0; overwrite = 1'b0;
        repeat (5) send_sample();
        chk_status("keep_old_full");
        repeat (4) do_pop("keep_old_pop", 1'b0);
        chk_status("keep_old_drain");
        do_ovf_clr();
        chk_status("ovf_clr");

        // full, drop oldest
        do_flush();
        overwrite = 1'b1;
        repeat (6) send_sample();
        chk_status("ovw_full");
        repeat (5) do_pop("ovw_pop", 1'b0);
        chk_status("ovw_drain");

        // write and pop in the same cycle with one frame stored
        do_flush();
        overwrite = 1'b0;
        send_sample();
        do_pop("wr_rd_same", 1'b1);
        chk_status("wr_rd_same");

        // flush while the pop burst is in RD2
        @(negedge clk); pop_req = 1'b1;
        @(negedge clk); pop_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_rd:in_rd2", 96'({mem_en, mem_we, mem_addr[1:0]}), 96'(4'b1010));
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        exp_q.delete(); ovf_m = 1'b0; since = 0;
        aborted = 0;
        repeat (10) begin
            @(negedge clk);
            if (pop_done) aborted++;
        end
        chk("flush_rd:no_done", 96'(aborted), 96'(0));
        chk_status("flush_rd");

        // watermark at 2 frames
        wmark = 3'd2;
        do_flush();
        send_sample();
        chk_status("wmark_1");
        send_sample();
        chk_status("wmark_2");

        // random mix of captures, pops and control changes
        wmark = 3'($urandom_range(0, DEPTH));
        odr_div = 4'($urandom_range(0, 2));
        do_flush();
        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(0, 10))
                0, 1, 2, 3, 4: send_sample();
                5, 6, 7:       do_pop("rnd_pop", 1'b0);
                8:             do_ovf_clr();
                9:             overwrite = 1'($urandom_range(0, 1));
                default: begin
                    fifo_en = 1'($urandom_range(0, 3) != 0);
                    if (!fifo_en) since = 0;
                end
            endcase
            chk_status("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
